// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry, address-width and wrapping pointer
// increment functions, and the per-cycle request decode.
package fifo_pkg;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Pointers carry one wrap bit above the address, so they count modulo 2*DEPTH.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer handshake bundle for sync_fifo_flags; the slave modport
// is the FIFO side, the master modport is the user side.
interface sync_fifo_flags_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    localparam int ADDR_WIDTH = addr_width(DEPTH);

    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en, err_clr,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, err_clr,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
// Contents are never reset.
module fifo_mem import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module sync_fifo_flags import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_flags_if.slave bus
);

    localparam int ADDR_WIDTH = addr_width(DEPTH);
    localparam int PW         = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rdata;
    fifo_op_e              w_op;

    // A read at full frees the slot the concurrent write lands in.
    assign w_full  = (r_count == PW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr_ok = bus.w_en & (~w_full | bus.r_en);
    assign w_rd_ok = bus.r_en & ~w_empty;
    assign w_op    = fifo_op_e'({w_wr_ok, w_rd_ok});

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok & ~rst),
        .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .i_wdata (bus.data_in),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= PW'(ptr_inc(32'(r_wptr), ADDR_WIDTH));
            end
            if (w_rd_ok) begin
                r_rptr <= PW'(ptr_inc(32'(r_rptr), ADDR_WIDTH));
            end
            unique case (w_op)
                OP_WR:   r_count <= r_count + ONE;
                OP_RD:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
            // A new error in the same cycle as err_clr stays visible.
            if (bus.w_en & w_full & ~bus.r_en) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end
            if (bus.r_en & w_empty) begin
                r_unf <= 1'b1;
            end else if (bus.err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = w_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= w_rdata;
                end
            end
            assign bus.data_out = r_dout;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= PW'(AF_LEVEL));
    assign bus.almost_empty = (r_count <= PW'(AE_LEVEL));
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a queue-based reference model for the
// standard-read instance plus directed steps for a fall-through instance.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) f0 ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) f1 ();

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(f0));
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .bus(f1));

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] q[$];
    int         m_cnt = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_out"},     32'(f0.data_out),     32'(m_dout));
        chk({tag, ".count"},        32'(f0.count),        32'(m_cnt));
        chk({tag, ".full"},         32'(f0.full),         32'(m_cnt == 16));
        chk({tag, ".empty"},        32'(f0.empty),        32'(m_cnt == 0));
        chk({tag, ".almost_full"},  32'(f0.almost_full),  32'(m_cnt >= 14));
        chk({tag, ".almost_empty"}, 32'(f0.almost_empty), 32'(m_cnt <= 2));
        chk({tag, ".overflow"},     32'(f0.overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(f0.underflow),    32'(m_unf));
    endtask

    // One clock on the standard instance; the model predicts and the bench checks.
    task automatic cyc(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic clr);
        logic m_full, m_empty, wr_ok, rd_ok;
        @(negedge clk);
        f0.w_en = w; f0.data_in = d; f0.r_en = r; f0.err_clr = clr;
        f1.w_en = 1'b0; f1.r_en = 1'b0; f1.err_clr = 1'b0;
        m_full  = (m_cnt == 16);
        m_empty = (m_cnt == 0);
        wr_ok   = w && (!m_full || r);
        rd_ok   = r && !m_empty;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        m_cnt = q.size();
        if (w && m_full && !r) m_ovf = 1'b1;
        else if (clr)          m_ovf = 1'b0;
        if (r && m_empty)      m_unf = 1'b1;
        else if (clr)          m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        f1.w_en = w; f1.data_in = d; f1.r_en = r; f1.err_clr = 1'b0;
        f0.w_en = 1'b0; f0.r_en = 1'b0; f0.err_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Requests presented during reset must be ignored and raise no errors.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        f0.w_en = 1'b1; f0.data_in = 8'hEE; f0.r_en = 1'b1; f0.err_clr = 1'b0;
        f1.w_en = 1'b1; f1.data_in = 8'hEE; f1.r_en = 1'b1; f1.err_clr = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_cnt = 0; m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
        f0.w_en = 1'b0; f0.r_en = 1'b0;
        f1.w_en = 1'b0; f1.r_en = 1'b0;
    endtask

    initial begin
        f0.w_en = 1'b0; f0.data_in = 8'h00; f0.r_en = 1'b0; f0.err_clr = 1'b0;
        f1.w_en = 1'b0; f1.data_in = 8'h00; f1.r_en = 1'b0; f1.err_clr = 1'b0;

        do_reset("reset");
        chk("reset.f1.empty", 32'(f1.empty), 32'd1);
        chk("reset.f1.count", 32'(f1.count), 32'd0);

        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);

        cyc("overflow",      1'b1, 8'h77, 1'b0, 1'b0);
        cyc("ovf_sticky",    1'b0, 8'h00, 1'b0, 1'b0);
        cyc("ovf_set_wins",  1'b1, 8'h78, 1'b0, 1'b1);
        cyc("ovf_clr",       1'b0, 8'h00, 1'b0, 1'b1);

        cyc("full_wr_rd",    1'b1, 8'hAA, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cyc("underflow",     1'b0, 8'h00, 1'b1, 1'b0);
        cyc("unf_sticky",    1'b0, 8'h00, 1'b0, 1'b0);
        cyc("unf_clr",       1'b0, 8'h00, 1'b0, 1'b1);

        cyc("empty_wr_rd",   1'b1, 8'h3C, 1'b1, 1'b0);
        cyc("unf_clr2",      1'b0, 8'h00, 1'b0, 1'b1);

        cyc("to3_a",         1'b1, 8'h41, 1'b0, 1'b0);
        cyc("to3_b",         1'b1, 8'h42, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc("wrap", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);

        cyc("pre_rst",       1'b1, 8'h99, 1'b1, 1'b0);
        do_reset("mid_reset");
        cyc("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        cyc("post_rst_wr",   1'b1, 8'h12, 1'b0, 1'b0);
        cyc("post_rst_rd",   1'b0, 8'h00, 1'b1, 1'b0);

        cyc1(1'b1, 8'h5C, 1'b0);
        chk("fwft.wr.data_out", 32'(f1.data_out), 32'h5C);
        chk("fwft.wr.empty",    32'(f1.empty),    32'd0);
        chk("fwft.wr.count",    32'(f1.count),    32'd1);
        cyc1(1'b0, 8'h00, 1'b0);
        chk("fwft.hold.data_out", 32'(f1.data_out), 32'h5C);
        cyc1(1'b0, 8'h00, 1'b1);
        chk("fwft.pop.empty",   32'(f1.empty),    32'd1);
        chk("fwft.pop.count",   32'(f1.count),    32'd0);
        cyc1(1'b1, 8'h11, 1'b0);
        cyc1(1'b1, 8'h22, 1'b0);
        chk("fwft.head1",       32'(f1.data_out), 32'h11);
        cyc1(1'b0, 8'h00, 1'b1);
        chk("fwft.head2",       32'(f1.data_out), 32'h22);
        chk("fwft.head2.empty", 32'(f1.empty),    32'd0);
        cyc1(1'b0, 8'h00, 1'b1);
        chk("fwft.drained",     32'(f1.empty),    32'd1);
        chk("fwft.underflow",   32'(f1.underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It is the general-purpose buffering block for the synchronous datapath, placed between any producer/consumer pair sharing one clock. It supersedes the fixed 8-deep, 8-bit FIFO.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- ADDR_WIDTH (localparam) = $clog2(DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request (pop)
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears overflow/underflow
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Pointers w_ptr/r_ptr are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address memory, MSB is wrap bit. Increment wraps modulo 2·DEPTH. count is a registered counter, kept consistent with w_ptr − r_ptr.
- Write accepted (wr_ok) when w_en & (!full | r_en). When full and r_en asserted, the read frees a slot in the same cycle: both accepted, count unchanged.
- Read accepted (rd_ok) when r_en & !empty. When empty and w_en asserted, write accepted, read rejected.
- count update: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- FWFT=0: on rd_ok, data_out ← mem[r_ptr] at the edge; otherwise data_out holds.
- FWFT=1: data_out continuously presents mem[r_ptr] (head word); valid whenever empty=0; rd_ok pops it. Value when empty is don't-care.
- overflow set when w_en & full & !r_en; underflow set when r_en & empty. Both hold until err_clr or rst; set wins over err_clr in the same cycle.
- All status outputs are decoded from registered count/pointers; no combinational path from w_en/r_en to any flag.
- Reset: w_ptr = r_ptr = 0, count = 0, data_out = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = underflow = 0. Memory array not reset. Reset mid-operation discards all stored words; requests in the reset cycle are ignored and flag no errors.

## Timing
- Write-to-visible: a word written at edge N is readable at edge N+1 (FWFT=1: on data_out, empty low, after edge N).
- FWFT=0 read latency: 1 cycle, data_out valid after the edge at which rd_ok was sampled.
- Flags and count reflect the result of edge N immediately after edge N.
- Sustained throughput: one write and one read per cycle at any occupancy, including full and (write-only) empty.

## Structure
- Shared package fifo_pkg: clog2-based address width function, default DEPTH/DATA_WIDTH constants, pointer increment function; reused by future FIFO variants.
- One sub-module: fifo_mem — DEPTH×DATA_WIDTH array, synchronous write port, asynchronous read port; FWFT=0 output register lives in the top level.
- Top level holds pointers, count, flag decode, error flags.

## Test plan
- Reset then 16 writes of 0x00..0x0F, no reads -> full=1 after 16th edge, count=16, almost_full=1 from count 14, overflow stays 0.
- 17th write with r_en=0 while full -> write dropped, overflow=1 sticky, count=16; err_clr pulse -> overflow=0.
- Read all 16 (FWFT=0) -> data_out 0x00..0x0F each one cycle after r_en, empty=1 after last, almost_empty=1 at count 2; extra r_en -> underflow=1.
- Simultaneous w_en & r_en at full with data_in=0xAA -> count stays 16, head advances, 0xAA read out 16 reads later; same at empty -> write only, underflow=1, count=1.
- FWFT=1: write 0x5C to empty -> data_out=0x5C and empty=0 after that edge with no r_en; r_en pops it, empty=1 next.
- Wrap: 40 interleaved write/read pairs at count 3 -> data order preserved across pointer wrap; rst asserted mid-stream -> count=0, empty=1, data_out=0 next cycle.
